// File: rtl/frame_deframer.sv
// Header-synchronised deframer: hunts for HDR_COUNT header words, then forwards FRAME_LEN payload words.
// Optional DEFRAMER_STATS_EN adds saturating frame_cnt / err_cnt outputs.
module frame_deframer #(
    parameter int          FRAME_LEN   = 64,
    parameter logic [15:0] HDR_WORD    = 16'hFFFF,
    parameter int          HDR_COUNT   = 3,
    parameter int          GAP_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        sof,
    output logic        eof,
    output logic        frame_err,
`ifdef DEFRAMER_STATS_EN
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt,
`endif
    output logic        locked
);

    localparam int WW = $clog2(FRAME_LEN + 1);
    localparam logic [WW-1:0] W_LAST = WW'(FRAME_LEN - 1);
    localparam logic [2:0]    H_LAST = 3'(HDR_COUNT - 1);
    localparam logic [7:0]    G_LAST = 8'(GAP_TIMEOUT - 1);

    typedef enum logic [1:0] {HUNT, HDR, PAYLOAD} state_t;

    state_t        state;
    logic [2:0]    hdr_cnt;
    logic [WW-1:0] word_cnt;
    logic [7:0]    gap_cnt;

    logic hit;
    assign hit = en && (data_in == HDR_WORD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            hdr_cnt    <= '0;
            word_cnt   <= '0;
            gap_cnt    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            sof        <= 1'b0;
            eof        <= 1'b0;
            frame_err  <= 1'b0;
            locked     <= 1'b0;
`ifdef DEFRAMER_STATS_EN
            frame_cnt  <= '0;
            err_cnt    <= '0;
`endif
        end else begin
            data_valid <= 1'b0;
            sof        <= 1'b0;
            eof        <= 1'b0;
            frame_err  <= 1'b0;
            unique case (state)
                HUNT: begin
                    if (hit) begin
                        if (HDR_COUNT == 1) begin
                            state    <= PAYLOAD;
                            locked   <= 1'b1;
                            hdr_cnt  <= '0;
                            word_cnt <= '0;
                            gap_cnt  <= '0;
                        end else begin
                            state   <= HDR;
                            hdr_cnt <= 3'd1;
                        end
                    end
                end
                HDR: begin
                    if (hit) begin
                        if (hdr_cnt == H_LAST) begin
                            state    <= PAYLOAD;
                            locked   <= 1'b1;
                            hdr_cnt  <= '0;
                            word_cnt <= '0;
                            gap_cnt  <= '0;
                        end else begin
                            hdr_cnt <= hdr_cnt + 3'd1;
                        end
                    end else if (en) begin
                        state   <= HUNT;
                        hdr_cnt <= '0;
                    end
                end
                PAYLOAD: begin
                    // Header-valued words are ordinary data once locked
                    if (en) begin
                        data_out   <= data_in;
                        data_valid <= 1'b1;
                        sof        <= (word_cnt == '0);
                        gap_cnt    <= '0;
                        if (word_cnt == W_LAST) begin
                            eof      <= 1'b1;
                            state    <= HUNT;
                            locked   <= 1'b0;
                            word_cnt <= '0;
                            hdr_cnt  <= '0;
`ifdef DEFRAMER_STATS_EN
                            if (frame_cnt != '1)
                                frame_cnt <= frame_cnt + 16'd1;
`endif
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end else if (gap_cnt == G_LAST) begin
                        frame_err <= 1'b1;
                        state     <= HUNT;
                        locked    <= 1'b0;
                        word_cnt  <= '0;
                        hdr_cnt   <= '0;
                        gap_cnt   <= '0;
`ifdef DEFRAMER_STATS_EN
                        if (err_cnt != '1)
                            err_cnt <= err_cnt + 8'd1;
`endif
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: begin
                    state  <= HUNT;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule
